// File: rtl/gray_arb_pkg.sv
// rtl/gray_arb_pkg.sv - shared defaults, owner encoding and read tag type for the gray port arbiter
package gray_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        OWN_R0 = 1'b0,
        OWN_R1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

endpackage

// File: rtl/gray_port_arbiter_if.sv
// rtl/gray_port_arbiter_if.sv - requester and gray memory read-port bundle
interface gray_port_arbiter_if
    import gray_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              mem_ready;
    logic              req_0;
    logic              req_1;
    logic [ADDR_W-1:0] addr_0;
    logic [ADDR_W-1:0] addr_1;
    logic              lock_0;
    logic              gnt_0;
    logic              gnt_1;
    logic [DATA_W-1:0] rdata_0;
    logic [DATA_W-1:0] rdata_1;
    logic              rvalid_0;
    logic              rvalid_1;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              idle;

    modport master (
        output mem_ready, req_0, req_1, addr_0, addr_1, lock_0, mem_rdata,
        input  gnt_0, gnt_1, rdata_0, rdata_1, rvalid_0, rvalid_1, mem_addr, mem_rd, idle
    );

    modport slave (
        input  mem_ready, req_0, req_1, addr_0, addr_1, lock_0, mem_rdata,
        output gnt_0, gnt_1, rdata_0, rdata_1, rvalid_0, rvalid_1, mem_addr, mem_rd, idle
    );
endinterface

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - shift register of read tags aligned with the memory read latency
module rd_tag_pipe
    import gray_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t push,
    output rd_tag_t out,
    output logic    any_valid
);
    rd_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= push;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign out = stage[DEPTH-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i].valid;
    end
endmodule

// File: rtl/gray_port_arbiter.sv
// rtl/gray_port_arbiter.sv - round-robin arbiter with bounded burst lock for the gray memory read port
module gray_port_arbiter
    import gray_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 9
) (
    input logic               clk,
    input logic               reset,
    gray_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    owner_e            last;
    logic              locked;
    logic [CNT_W-1:0]  lock_cnt;
    logic              g0, g1, acc, starve, tag_busy;
    owner_e            win;
    rd_tag_t           tag_in, tag_out;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] ret_data;

    // Requester 1 gets one slot once the lock has held it off for MAX_LOCK grants
    assign starve = locked && bus.req_0 && bus.req_1 && (lock_cnt == CNT_W'(MAX_LOCK));

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (bus.mem_ready) begin
            if (locked && bus.req_0) begin
                g1 = starve;
                g0 = !starve;
            end else if (bus.req_0 && bus.req_1) begin
                g0 = (last == OWN_R1);
                g1 = (last == OWN_R0);
            end else begin
                g0 = bus.req_0;
                g1 = bus.req_1;
            end
        end
    end

    assign acc      = g0 | g1;
    assign win      = g1 ? OWN_R1 : OWN_R0;
    assign sel_addr = g1 ? bus.addr_1 : bus.addr_0;
    assign ret_data = bus.mem_rdata;
    assign tag_in   = '{valid: acc, owner: win};
    assign bus.gnt_0 = g0;
    assign bus.gnt_1 = g1;
    assign bus.idle  = !tag_busy && !bus.mem_rd;

    rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .push      (tag_in),
        .out       (tag_out),
        .any_valid (tag_busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_addr <= '0;
            bus.mem_rd   <= 1'b0;
            bus.rdata_0  <= '0;
            bus.rdata_1  <= '0;
            bus.rvalid_0 <= 1'b0;
            bus.rvalid_1 <= 1'b0;
            last         <= OWN_R1;
            locked       <= 1'b0;
            lock_cnt     <= '0;
        end else begin
            bus.mem_rd <= acc;
            if (acc) begin
                bus.mem_addr <= sel_addr;
                last         <= win;
            end

            if (!bus.req_0) begin
                locked   <= 1'b0;
                lock_cnt <= '0;
            end else if (g0) begin
                locked   <= bus.lock_0;
                lock_cnt <= (bus.lock_0 && bus.req_1) ? lock_cnt + CNT_W'(1) : '0;
            end else if (g1 || !bus.req_1) begin
                lock_cnt <= '0;
            end

            bus.rvalid_0 <= tag_out.valid && (tag_out.owner == OWN_R0);
            bus.rvalid_1 <= tag_out.valid && (tag_out.owner == OWN_R1);
            if (tag_out.valid && tag_out.owner == OWN_R0) bus.rdata_0 <= ret_data;
            if (tag_out.valid && tag_out.owner == OWN_R1) bus.rdata_1 <= ret_data;
        end
    end
endmodule

// File: tb/tb_gray_port_arbiter.sv
// tb/tb_gray_port_arbiter.sv - scoreboard bench for gray_port_arbiter with a reference memory and arbitration model
module tb_gray_port_arbiter;
    import gray_arb_pkg::*;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 8;
    localparam int RD_LAT   = 1;
    localparam int MAX_LOCK = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gray_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    gray_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic [7:0] data; int cyc; } ret_t;
    typedef struct { logic [13:0] addr; int cyc; } iss_t;

    ret_t       rq0[$];
    ret_t       rq1[$];
    iss_t       iq[$];
    logic [7:0] mem [16384];
    int         sched[int];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    // Reference arbitration state
    int m_last   = 1;
    bit m_locked = 1'b0;
    int m_cnt    = 0;
    int last_acc = -100;
    logic [7:0] exp_rd0 = 8'h00;
    logic [7:0] exp_rd1 = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int model_winner(bit r0, bit r1, bit rdy);
        if (!rdy) return -1;
        if (m_locked && r0) return (r1 && m_cnt == MAX_LOCK) ? 1 : 0;
        if (r0 && r1) return (m_last == 0) ? 1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic void model_update(int w, bit r0, bit l0, bit r1);
        if (w >= 0) m_last = w;
        if (!r0) begin
            m_locked = 1'b0;
            m_cnt = 0;
        end else if (w == 0) begin
            m_locked = l0;
            m_cnt = (l0 && r1) ? m_cnt + 1 : 0;
        end else if (w == 1 || !r1) begin
            m_cnt = 0;
        end
    endfunction

    task automatic step(input bit r0, input logic [13:0] a0, input bit l0, input bit r1,
                        input logic [13:0] a1, input bit rdy, input bit rst, output int w);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.req_0     = r0;
        bus.addr_0    = a0;
        bus.lock_0    = l0;
        bus.req_1     = r1;
        bus.addr_1    = a1;
        bus.mem_ready = rdy;
        #1;
        chk("idle", bus.idle, (cyc - last_acc > RD_LAT + 1) ? 1 : 0);
        w = model_winner(r0, r1, rdy);
        chk("gnt_0", bus.gnt_0, (w == 0) ? 1 : 0);
        chk("gnt_1", bus.gnt_1, (w == 1) ? 1 : 0);
        if (w == 0) begin
            iq.push_back('{addr: a0, cyc: cyc + 1});
            rq0.push_back('{data: mem[a0], cyc: cyc + RD_LAT + 2});
            last_acc = cyc;
        end else if (w == 1) begin
            iq.push_back('{addr: a1, cyc: cyc + 1});
            rq1.push_back('{data: mem[a1], cyc: cyc + RD_LAT + 2});
            last_acc = cyc;
        end
        model_update(w, r0, l0, r1);
        if (rst) begin
            m_last = 1;
            m_locked = 1'b0;
            m_cnt = 0;
            last_acc = -100;
            while (rq0.size() > 0 && rq0[$].cyc > cyc) void'(rq0.pop_back());
            while (rq1.size() > 0 && rq1[$].cyc > cyc) void'(rq1.pop_back());
        end
    endtask

    // Memory model and output monitor, sampled mid-cycle
    always @(negedge clk) begin
        iss_t e;
        ret_t r;
        if (bus.mem_rd === 1'b1) sched[cyc + RD_LAT] = int'(mem[bus.mem_addr]);
        if (sched.exists(cyc)) begin
            bus.mem_rdata = 8'(sched[cyc]);
            sched.delete(cyc);
        end else begin
            bus.mem_rdata = 8'($urandom);
        end

        if (iq.size() > 0 && iq[0].cyc <= cyc) begin
            e = iq.pop_front();
            chk("mem_rd", bus.mem_rd, 1);
            chk("mem_addr", bus.mem_addr, e.addr);
        end else begin
            chk("mem_rd_quiet", bus.mem_rd, 0);
        end

        if (rq0.size() > 0 && rq0[0].cyc <= cyc) begin
            r = rq0.pop_front();
            chk("rvalid_0", bus.rvalid_0, 1);
            chk("rdata_0", bus.rdata_0, r.data);
            exp_rd0 = r.data;
        end else begin
            chk("rvalid_0_quiet", bus.rvalid_0, 0);
            if (!reset) chk("rdata_0_hold", bus.rdata_0, exp_rd0);
        end

        if (rq1.size() > 0 && rq1[0].cyc <= cyc) begin
            r = rq1.pop_front();
            chk("rvalid_1", bus.rvalid_1, 1);
            chk("rdata_1", bus.rdata_1, r.data);
            exp_rd1 = r.data;
        end else begin
            chk("rvalid_1_quiet", bus.rvalid_1, 0);
            if (!reset) chk("rdata_1_hold", bus.rdata_1, exp_rd1);
        end

        if (reset) begin
            exp_rd0 = 8'h00;
            exp_rd1 = 8'h00;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int p0, p1, pl, pr;
        bus.req_0 = 1'b0; bus.req_1 = 1'b0; bus.lock_0 = 1'b0; bus.mem_ready = 1'b1;
        bus.addr_0 = '0; bus.addr_1 = '0; bus.mem_rdata = '0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
        mem[14'h0081] = 8'h5A;

        repeat (3) step(0, 0, 0, 0, 0, 1, 1, w);
        step(0, 0, 0, 0, 0, 1, 0, w);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_rvalid", {bus.rvalid_1, bus.rvalid_0}, 0);
        chk("rst_rdata", {bus.rdata_1, bus.rdata_0}, 0);
        chk("rst_idle", bus.idle, 1);

        // Single read timing
        step(1, 14'h0081, 0, 0, 0, 1, 0, w);
        step(0, 0, 0, 0, 0, 1, 0, w);
        chk("single_mem_addr", bus.mem_addr, 14'h0081);
        chk("single_mem_rd", bus.mem_rd, 1);
        step(0, 0, 0, 0, 0, 1, 0, w);
        step(0, 0, 0, 0, 0, 1, 0, w);
        chk("single_rvalid_0", bus.rvalid_0, 1);
        chk("single_rdata_0", bus.rdata_0, 8'h5A);
        step(0, 0, 0, 0, 0, 1, 0, w);
        chk("single_idle", bus.idle, 1);

        // Round robin under conflict, starting from last = requester 1
        step(0, 0, 0, 1, 14'h0020, 1, 0, w);
        for (int i = 0; i < 4; i++) begin
            step(1, 14'h0010, 0, 1, 14'h0020, 1, 0, w);
            chk("rr_gnt_1", bus.gnt_1, i % 2);
        end

        // Lock burst bounded by MAX_LOCK
        step(0, 0, 0, 0, 0, 1, 0, w);
        step(0, 0, 0, 1, 14'($urandom), 1, 0, w);
        for (int i = 0; i < 12; i++) begin
            step(1, 14'($urandom), 1, 1, 14'($urandom), 1, 0, w);
            chk("lock_burst_gnt_1", bus.gnt_1, (i == 9) ? 1 : 0);
        end

        // Lock released on the 5th accept
        step(0, 0, 0, 0, 0, 1, 0, w);
        step(0, 0, 0, 1, 14'($urandom), 1, 0, w);
        for (int i = 0; i < 5; i++) begin
            step(1, 14'($urandom), (i < 4) ? 1'b1 : 1'b0, 1, 14'($urandom), 1, 0, w);
            chk("lock_rel_gnt_0", bus.gnt_0, 1);
        end
        step(1, 14'($urandom), 0, 1, 14'($urandom), 1, 0, w);
        chk("lock_rel_after_gnt_1", bus.gnt_1, 1);

        // mem_ready gating with reads in flight
        step(0, 0, 0, 0, 0, 1, 0, w);
        step(1, 14'h0010, 0, 1, 14'h0020, 1, 0, w);
        step(1, 14'h0010, 0, 1, 14'h0020, 1, 0, w);
        for (int i = 0; i < 3; i++) begin
            step(1, 14'h0010, 0, 1, 14'h0020, 0, 0, w);
            chk("gate_gnt", {bus.gnt_1, bus.gnt_0}, 0);
            if (i > 0) chk("gate_mem_rd", bus.mem_rd, 0);
        end
        repeat (4) step(0, 0, 0, 0, 0, 1, 0, w);

        // Reset while a read is in flight
        step(1, 14'h0100, 0, 0, 0, 1, 0, w);
        step(0, 0, 0, 0, 0, 1, 1, w);
        step(0, 0, 0, 0, 0, 1, 0, w);
        chk("midrst_mem_rd", bus.mem_rd, 0);
        chk("midrst_idle", bus.idle, 1);
        step(0, 0, 0, 0, 0, 1, 0, w);
        chk("midrst_rvalid_0", bus.rvalid_0, 0);

        // Randomised traffic in biased segments
        for (int s = 0; s < 60; s++) begin
            p0 = $urandom_range(30, 100);
            p1 = $urandom_range(20, 100);
            pl = $urandom_range(0, 100);
            pr = $urandom_range(60, 100);
            for (int i = 0; i < 50; i++) begin
                step(($urandom_range(99) < p0), 14'($urandom), ($urandom_range(99) < pl),
                     ($urandom_range(99) < p1), 14'($urandom), ($urandom_range(99) < pr), 0, w);
            end
        end
        repeat (8) step(0, 0, 0, 0, 0, 1, 0, w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gray_port_arbiter.md
Name: gray_port_arbiter

Overview:
- Shares the single gray-image memory read port (14-bit address, 8-bit data) between two requesters.
  - Requester 0: the LBP window engine.
  - Requester 1: a secondary reader, e.g. histogram or debug readback.
- Round-robin arbitration, with a lock so requester 0 can hold the port for a 3x3 window burst.
- Lock hold is bounded against starvation.
- Tags in-flight reads and routes returned data back to the owner at a fixed latency.

Parameters:
- ADDR_W, 14, gray memory address width (128x128 image).
- DATA_W, 8, pixel width.
- RD_LAT, 1, memory read latency: cycles from the mem_rd sampling edge to mem_rdata valid; range 1..4.
- MAX_LOCK, 9, maximum consecutive locked grants to requester 0 while requester 1 is waiting.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mem_ready  in  1  memory available (gray_ready); no new grants while low.
- req_0, req_1  in  1  read request.
- addr_0, addr_1  in  ADDR_W  read address, valid with req.
- lock_0  in  1  requester 0 burst lock, meaningful with req_0.
- gnt_0, gnt_1  out  1  combinational grant; req_x & gnt_x in a cycle = accepted read.
- rdata_0, rdata_1  out  DATA_W  returned pixel.
- rvalid_0, rvalid_1  out  1  one-cycle strobe qualifying rdata_x.
- mem_addr  out  ADDR_W  registered read address.
- mem_rd  out  1  registered read strobe.
- mem_rdata  in  DATA_W  memory read data.
- idle  out  1  no accepted read still in flight.

Behaviour:
- Reset (synchronous):
  - mem_addr=0, mem_rd=0, rdata_x=0, rvalid_x=0, idle=1.
  - Round-robin pointer last=1, so requester 0 wins the first conflict.
  - Lock state cleared; lock counter=0; tag pipe flushed.
  - A reset mid-operation drops all in-flight reads: no rvalid after reset.
- Grant (combinational, at most one gnt high per cycle):
  - mem_ready=0 → both gnt low.
  - Locked state active and req_0=1 → gnt_0, unless the starvation rule fires.
  - Only one req high → that requester is granted.
  - Both high, not locked → grant the requester not equal to last.
- On every accepted cycle:
  - last <= winner.
  - Next edge: mem_addr <= winner's addr, mem_rd <= 1.
  - Cycles with no accept: mem_rd <= 0, mem_addr holds its value.
- Lock:
  - Enter the locked state when requester 0 is accepted with lock_0=1.
  - Leave it when requester 0 is accepted with lock_0=0, or req_0=0 in any cycle.
  - lock_cnt counts consecutive locked gnt_0 accepts while req_1=1; cleared when req_1=0 or the lock exits.
- Starvation rule:
  - When lock_cnt==MAX_LOCK and req_1=1, the next grant goes to requester 1 for exactly one transfer.
  - lock_cnt then clears; the locked state is retained and requester 0 resumes afterwards.
- Tag pipe:
  - Each accept pushes {valid=1, owner}; non-accept cycles push valid=0.
  - Depth RD_LAT+1.
  - At the output stage, rdata_owner <= mem_rdata and rvalid_owner <= 1 on the same edge; the other rvalid <= 0.
  - rdata_x holds its value between strobes.
- Latency:
  - Accept in cycle 0 → mem_rd/mem_addr visible in cycle 1 → rvalid in cycle RD_LAT+2 (cycle 3 at default).
  - Throughput is one read per cycle; back-to-back accepts return back-to-back in order.
- idle = no valid tag in the pipe and mem_rd=0.
- Simultaneous events:
  - Requester 1 accept plus requester 0 data return in the same cycle: both proceed independently.
  - mem_ready falling does not cancel issued reads.
- Address arithmetic:
  - The arbiter passes addresses unmodified; no wrap or range check.
  - Out-of-image addresses are the requester's responsibility.

Decomposition:
- gray_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - Owner encoding OWN_R0=0, OWN_R1=1.
  - Tag struct {valid, owner}.
- One sub-module, rd_tag_pipe: parameterised shift register of tags (depth RD_LAT+1), with a synchronous flush on reset.
- Arbitration and lock logic stay in the top.

Test Plan:
- Single read: req_0=1, addr_0=0x0081, mem_rdata=0x5A at return → gnt_0 in cycle 0; mem_addr=0x0081, mem_rd=1 in cycle 1; rvalid_0=1, rdata_0=0x5A in cycle 3; idle=1 in cycle 4.
- Conflict round robin: req_0 and req_1 held for 4 cycles, addresses 0x10/0x20 → grants alternate r0,r1,r0,r1; mem_addr 0x10,0x20,0x10,0x20; rvalid routed to the matching owner in order.
- Lock burst: lock_0=1 with req_0 for 9 accepts while req_1=1, MAX_LOCK=9 → 9 gnt_0, then one gnt_1, then gnt_0 resumes.
- Lock release: lock_0 low on the 5th accept → the next conflict grants r1.
- mem_ready gating: mem_ready=0 for 3 cycles with both reqs high → no gnt, mem_rd=0; reads already in flight still return.
- Reset mid-flight: reset asserted in cycle 1 after an accept → no rvalid in cycle 3; mem_rd=0 and idle=1 after reset.
